mantissa_normalizer: RTL and testbench
======================================

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  mant_in/exp_in are valid this cycle.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 mant_in  input  24  unnormalized mantissa, bit 23 is the hidden-bit position.
REQ-007 exp_in  input  8  biased exponent belonging to mant_in.
REQ-008 out_valid  output  1  result fields are valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 mant_out  output  24  left-shifted (normalized) mantissa.
REQ-011 exp_out  output  8  exp_in minus applied shift.
REQ-012 sh_out  output  5  applied left-shift amount, 0..23.
REQ-013 zero  output  1  mant_in was zero.
REQ-014 underflow  output  1  shift was limited by exp_in; result is denormal.

Function
REQ-015 States SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 at edge E captures mant_in/exp_in, clears the shift accumulator and the stage counter, and enters SHIFT.
REQ-017 SHIFT SHALL run exactly 5 cycles, one stage per cycle, in the order 16, 8, 4, 2, 1.
REQ-018 Stage k SHALL shift the working mantissa left by k, zero-filling from the LSB, only if its top k bits are all zero AND accumulator+k <= captured exp_in; otherwise it SHALL pass the value unchanged.
REQ-019 When a stage shifts, the accumulator SHALL increase by k; the final accumulator equals min(leading-zero count, exp_in).
REQ-020 At edge E+5 the block SHALL enter DONE, with out_valid=1 and mant_out, exp_out=exp_in-accumulator, sh_out=accumulator, zero and underflow all registered and stable.
REQ-021 underflow SHALL be 1 iff mant_in!=0 and bit 23 of the final mantissa is 0.
REQ-022 If mant_in==0, the block SHALL output zero=1, mant_out=0, exp_out=0, sh_out=0, underflow=0, with the same 5-cycle latency.
REQ-023 DONE: all outputs SHALL hold while out_ready=0; out_valid=1 and out_ready=1 at an edge SHALL return the block to IDLE with out_valid=0.
REQ-024 in_valid SHALL be ignored outside IDLE; there is no input buffering, so throughput is one operand per 7 cycles minimum (accept, 5 shift cycles, 1 handshake cycle).
REQ-025 exp_out SHALL never wrap below 0, which REQ-018 guarantees.

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, and mant_out, exp_out, sh_out, zero and underflow all 0.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation immediately; no out_valid pulse follows reset release.
REQ-028 The first in_valid SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-029 mant_in=0x000001, exp_in=100 -> at E+5: mant_out=0x800000, exp_out=77, sh_out=23, zero=0, underflow=0.
REQ-030 mant_in=0x800000, exp_in=5 -> mant_out=0x800000, exp_out=5, sh_out=0, flags 0.
REQ-031 mant_in=0x000100, exp_in=3 -> mant_out=0x000800, exp_out=0, sh_out=3, underflow=1.
REQ-032 mant_in=0x000000, exp_in=50 -> zero=1, mant_out=0, exp_out=0, sh_out=0, underflow=0.
REQ-033 Hold out_ready=0 for 3 cycles after out_valid -> outputs stable and in_ready=0; new in_valid is ignored; after the handshake, the next operand is accepted in IDLE.
REQ-034 Assert rst_n=0 during the 3rd SHIFT cycle -> all outputs are 0 immediately, out_valid is never asserted for that operand, and in_ready=1 after release.

Source files
------------

// File: rtl/mantissa_normalizer_if.sv
// Operand/result handshake bundle for mantissa_normalizer.
// The slave modport is the normalizer's view. The master modport is the driver/consumer view.
interface mantissa_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mant_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant_out;
  logic [7:0]  exp_out;
  logic [4:0]  sh_out;
  logic        zero;
  logic        underflow;

  modport slave (
    input  in_valid, mant_in, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sh_out, zero, underflow
  );

  modport master (
    output in_valid, mant_in, exp_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sh_out, zero, underflow
  );
endinterface

// File: rtl/mantissa_normalizer.sv
// Five-stage (16/8/4/2/1) iterative mantissa normalizer.
// The left shift is limited by the biased exponent, so the block yields denormals instead of wrapping the exponent.
module mantissa_normalizer (
  input  logic                        clk,
  input  logic                        rst_n,
  mantissa_normalizer_if.slave        bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [2:0] LAST_STAGE = 3'd4;

  logic [1:0]  r_state;
  logic [23:0] r_mant;
  logic [7:0]  r_exp;
  logic [4:0]  r_acc;
  logic [2:0]  r_stage;
  logic        r_zero_cap;

  logic        r_in_ready;
  logic        r_out_valid;
  logic [23:0] r_mant_out;
  logic [7:0]  r_exp_out;
  logic [4:0]  r_sh_out;
  logic        r_zero;
  logic        r_underflow;

  logic [4:0]  w_k;
  logic        w_top_zero;
  logic        w_fits;
  logic        w_do_shift;
  logic [23:0] w_mant_nxt;
  logic [4:0]  w_acc_nxt;
  logic [23:0] w_mant_res;
  logic [7:0]  w_exp_res;
  logic [4:0]  w_sh_res;
  logic        w_uf_res;

  // Current stage: shift by k when the top k bits are clear and the exponent budget allows it
  always_comb begin
    w_k        = 5'd1;
    w_top_zero = 1'b0;
    case (r_stage)
      3'd0: begin w_k = 5'd16; w_top_zero = (r_mant[23:8]  == 16'd0); end
      3'd1: begin w_k = 5'd8;  w_top_zero = (r_mant[23:16] == 8'd0);  end
      3'd2: begin w_k = 5'd4;  w_top_zero = (r_mant[23:20] == 4'd0);  end
      3'd3: begin w_k = 5'd2;  w_top_zero = (r_mant[23:22] == 2'd0);  end
      3'd4: begin w_k = 5'd1;  w_top_zero = ~r_mant[23];              end
      default: begin w_k = 5'd1; w_top_zero = 1'b0; end
    endcase
    w_fits     = ({4'd0, r_acc} + {4'd0, w_k}) <= {1'b0, r_exp};
    w_do_shift = w_top_zero & w_fits;
    if (w_do_shift) begin
      w_mant_nxt = r_mant << w_k;
      w_acc_nxt  = r_acc + w_k;
    end else begin
      w_mant_nxt = r_mant;
      w_acc_nxt  = r_acc;
    end
    // A zero operand reports all-zero fields regardless of what the stages did
    if (r_zero_cap) begin
      w_mant_res = 24'd0;
      w_exp_res  = 8'd0;
      w_sh_res   = 5'd0;
      w_uf_res   = 1'b0;
    end else begin
      w_mant_res = w_mant_nxt;
      w_exp_res  = r_exp - {3'd0, w_acc_nxt};
      w_sh_res   = w_acc_nxt;
      w_uf_res   = ~w_mant_nxt[23];
    end
  end

  // Control FSM and working datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mant     <= 24'd0;
      r_exp      <= 8'd0;
      r_acc      <= 5'd0;
      r_stage    <= 3'd0;
      r_zero_cap <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_mant     <= bus.mant_in;
            r_exp      <= bus.exp_in;
            r_zero_cap <= (bus.mant_in == 24'd0);
            r_acc      <= 5'd0;
            r_stage    <= 3'd0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_mant  <= w_mant_nxt;
          r_acc   <= w_acc_nxt;
          r_stage <= r_stage + 3'd1;
          if (r_stage == LAST_STAGE) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Registered handshake and result fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mant_out  <= 24'd0;
      r_exp_out   <= 8'd0;
      r_sh_out    <= 5'd0;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_stage == LAST_STAGE) begin
            r_out_valid <= 1'b1;
            r_mant_out  <= w_mant_res;
            r_exp_out   <= w_exp_res;
            r_sh_out    <= w_sh_res;
            r_zero      <= r_zero_cap;
            r_underflow <= w_uf_res;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.mant_out  = r_mant_out;
  assign bus.exp_out   = r_exp_out;
  assign bus.sh_out    = r_sh_out;
  assign bus.zero      = r_zero;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// Self-checking bench for mantissa_normalizer: directed table, handshake/reset corners, random ops vs. model.
module tb_mantissa_normalizer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mantissa_normalizer_if bus ();
  mantissa_normalizer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [23:0] m_o;
    logic [7:0]  e_o;
    logic [4:0]  sh;
    logic        z;
    logic        uf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Normalization from first principles: count leading zeros, clamp by exponent
  function automatic void model(input logic [23:0] m, input logic [7:0] e,
                                output logic [23:0] mo, output logic [7:0] eo,
                                output logic [4:0] sh, output logic z, output logic uf);
    int lz;
    int s;
    bit found;
    lz = 24;
    found = 0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz = 23 - i;
        found = 1;
      end
    end
    if (m == 24'd0) begin
      mo = 24'd0; eo = 8'd0; sh = 5'd0; z = 1'b1; uf = 1'b0;
    end else begin
      s  = (lz < int'(e)) ? lz : int'(e);
      mo = m << s;
      eo = e - 8'(s);
      sh = 5'(s);
      z  = 1'b0;
      uf = ~mo[23];
    end
  endfunction

  task automatic start_op(input logic [23:0] m, input logic [7:0] e, input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready_wait"}, 32'(n < 50), 32'd1);
    bus.in_valid = 1'b1;
    bus.mant_in  = m;
    bus.exp_in   = e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, " in_ready_low"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd5);
  endtask

  task automatic check_fields(input string tag, input logic [23:0] mo, input logic [7:0] eo,
                              input logic [4:0] sh, input logic z, input logic uf);
    chk({tag, " mant_out"},  32'(bus.mant_out),  32'(mo));
    chk({tag, " exp_out"},   32'(bus.exp_out),   32'(eo));
    chk({tag, " sh_out"},    32'(bus.sh_out),    32'(sh));
    chk({tag, " zero"},      32'(bus.zero),      32'(z));
    chk({tag, " underflow"}, 32'(bus.underflow), 32'(uf));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid_cleared"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready_back"},     32'(bus.in_ready),  32'd1);
  endtask

  task automatic run_op(input logic [23:0] m, input logic [7:0] e, input logic [23:0] mo,
                        input logic [7:0] eo, input logic [4:0] sh, input logic z,
                        input logic uf, input string tag);
    start_op(m, e, tag);
    wait_result(tag);
    check_fields(tag, mo, eo, sh, z, uf);
    handshake(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check_fields(tag, 24'd0, 8'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [23:0] rm, mo;
    logic [7:0]  re, eo;
    logic [4:0]  sh;
    logic        z, uf;
    bit          seen_valid;

    vecs[0] = '{24'h000001, 8'd100, 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0};
    vecs[1] = '{24'h800000, 8'd5,   24'h800000, 8'd5,  5'd0,  1'b0, 1'b0};
    vecs[2] = '{24'h000100, 8'd3,   24'h000800, 8'd0,  5'd3,  1'b0, 1'b1};
    vecs[3] = '{24'h000000, 8'd50,  24'h000000, 8'd0,  5'd0,  1'b1, 1'b0};
    vecs[4] = '{24'hFFFFFF, 8'd0,   24'hFFFFFF, 8'd0,  5'd0,  1'b0, 1'b0};
    vecs[5] = '{24'h000001, 8'd0,   24'h000001, 8'd0,  5'd0,  1'b0, 1'b1};
    vecs[6] = '{24'h400000, 8'd1,   24'h800000, 8'd0,  5'd1,  1'b0, 1'b0};
    vecs[7] = '{24'h000001, 8'd10,  24'h000400, 8'd0,  5'd10, 1'b0, 1'b1};
    vecs[8] = '{24'h00ABCD, 8'd255, 24'hABCD00, 8'd247, 5'd8, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mant_in   = 24'd0;
    bus.exp_in    = 8'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].mant, vecs[i].exp, vecs[i].m_o, vecs[i].e_o, vecs[i].sh,
             vecs[i].z, vecs[i].uf, $sformatf("vec%0d", i));
    end

    // Result held under back-pressure, new operand ignored while busy
    start_op(24'h000001, 8'd100, "hold");
    wait_result("hold");
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.mant_in  = 24'h123456;
      bus.exp_in   = 8'd7;
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", c),  32'(bus.in_ready),  32'd0);
      check_fields($sformatf("hold%0d", c), 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);
    end
    bus.in_valid = 1'b0;
    handshake("hold");
    run_op(24'h800000, 8'd5, 24'h800000, 8'd5, 5'd0, 1'b0, 1'b0, "after_hold");

    // Reset during the third shift cycle aborts the operation
    start_op(24'h000001, 8'd100, "abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_now");
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1;
    end
    chk("abort no_out_valid", 32'(seen_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);

    // Operand presented at reset release is taken on the first edge
    rst_n = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant_in  = 24'h000100;
    bus.exp_in   = 8'd3;
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("first_edge accepted", 32'(bus.in_ready), 32'd0);
    wait_result("first_edge");
    check_fields("first_edge", 24'h000800, 8'd0, 5'd3, 1'b0, 1'b1);
    handshake("first_edge");

    for (int r = 0; r < 150; r++) begin
      rm = 24'($urandom) >> $urandom_range(0, 24);
      re = (r % 2 == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      model(rm, re, mo, eo, sh, z, uf);
      run_op(rm, re, mo, eo, sh, z, uf, $sformatf("rnd%0d m=%06h e=%0d", r, rm, re));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
